// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default oversample ratio and
// parity helpers, common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR-reduction of the payload; true when the received
  // parity bit disagrees with the configured mode.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic sample,
                                           input logic mode);
    return (data_xor ^ sample) != mode;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a falling-edge pulse.
// Edges are only reported once the synchronised line has been seen high after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] live_q, live_d;
  logic       prev_q, prev_d;

  // live_q marks when sync2_q holds a real line sample rather than its reset
  // value, so a line already low at reset release cannot look like an edge.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    live_d  = {live_q[0], 1'b1};
    prev_d  = live_q[1] & sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      live_q  <= 2'b00;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      live_q  <= live_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: deserialises rx using the 16x oversample tick, with parity,
// framing and overrun reporting and a valid/ready output register.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_MODE = PARITY_ODD ? PAR_ODD : PAR_EVEN;

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 ovr_pend_q, ovr_pend_d;
  logic                 busy_q, busy_d;
  logic                 deliver;
  logic                 accept;

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    par_err_d     = par_err_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = frame_err_q;
    parity_err_d  = parity_err_q;
    overrun_err_d = overrun_err_q;
    ovr_pend_d    = ovr_pend_q;
    deliver       = 1'b0;
    accept        = rx_valid_q & rx_ready;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d    = '0;
            bit_d     = '0;
            par_err_d = 1'b0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_END) begin
            tick_d    = '0;
            par_err_d = parity_mismatch(^shift_q, rx_s, PAR_MODE);
            state_d   = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The held word already flags an overrun, so accepting it consumes the report.
    if (accept) begin
      rx_valid_d = 1'b0;
      ovr_pend_d = 1'b0;
    end

    if (deliver) begin
      if (!rx_valid_q || accept) begin
        rx_valid_d    = 1'b1;
        rx_data_d     = shift_q;
        frame_err_d   = ~rx_s;
        parity_err_d  = PARITY_EN ? par_err_q : 1'b0;
        overrun_err_d = ovr_pend_q & ~accept;
        ovr_pend_d    = 1'b0;
      end else begin
        ovr_pend_d    = 1'b1;
        overrun_err_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      ovr_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      ovr_pend_q    <= ovr_pend_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench: two receivers (8N1 and 8E1) fed by a bit-level serialiser;
// expected words are queued at send time and popped by per-receiver monitors.
module tb_uart_rx_oversample;

  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_ready_p = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

  int   total = 0;
  int   bad = 0;
  int   mode0 = 0;
  int   mode1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  uart_rx_oversample dut_n (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
    .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0), .busy(busy0)
  );

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx_p),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready_p),
    .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    int tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      s_tick = (tcnt % 4 == 0);
    end
  end

  // mode: 0 = always ready, 1 = random ready, 2 = never ready
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rx_ready   = (mode0 == 1) ? 1'($urandom_range(0, 1)) : (mode0 == 0);
      rx_ready_p = (mode1 == 1) ? 1'($urandom_range(0, 1)) : (mode1 == 0);
    end
  end

  function automatic logic even_par_err(input logic [7:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cmp_word(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got data=%h fe=%b pe=%b ov=%b want data=%h fe=%b pe=%b ov=%b",
               name, act.data, act.fe, act.pe, act.ov, exp.data, exp.fe, exp.pe, exp.ov);
    end else begin
      $display("%s accept data=%h fe=%b pe=%b ov=%b", name, act.data, act.fe, act.pe, act.ov);
    end
  endtask

  // Monitor for the 8N1 receiver
  initial begin
    logic [7:0] held = '0;
    logic       hold_v = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v) chk("hold_n", {23'd0, rx_valid0, rx_data0}, {23'd0, 1'b1, held});
      if (rx_valid0 && rx_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_n: got data=%h fe=%b want no word", rx_data0, fe0);
        end else begin
          e = q0.pop_front();
          cmp_word("rx_n", {rx_data0, fe0, pe0, ov0}, e);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = rx_valid0;
        held   = rx_data0;
      end
    end
  end

  // Monitor for the 8E1 receiver
  initial begin
    logic [7:0] held = '0;
    logic       hold_v = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v) chk("hold_p", {23'd0, rx_valid1, rx_data1}, {23'd0, 1'b1, held});
      if (rx_valid1 && rx_ready_p) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_p: got data=%h fe=%b want no word", rx_data1, fe1);
        end else begin
          e = q1.pop_front();
          cmp_word("rx_p", {rx_data1, fe1, pe1, ov1}, e);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = rx_valid1;
        held   = rx_data1;
      end
    end
  end

  task automatic drive(input int ch, input logic v);
    if (ch == 0) rx = v; else rx_p = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity, stop; the line is left at the stop level.
  task automatic send(input int ch, input logic [7:0] d, input logic stop, input logic pbit);
    drive(ch, 1'b0);
    for (int i = 0; i < 8; i++) drive(ch, d[i]);
    if (ch == 1) drive(ch, pbit);
    drive(ch, stop);
  endtask

  task automatic send_exp(input int ch, input logic [7:0] d, input logic stop, input logic pbit);
    exp_t e;
    e.data = d;
    e.fe   = ~stop;
    e.pe   = (ch == 1) ? even_par_err(d, pbit) : 1'b0;
    e.ov   = 1'b0;
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
    send(ch, d, stop, pbit);
    if (ch == 0) rx = 1'b1; else rx_p = 1'b1;
    repeat ($urandom_range(8, 40)) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_%s: got %0d/%0d words pending want 0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] d;
    logic       st, pb;

    repeat (5) @(negedge clk);
    chk("rst_valid", {30'd0, rx_valid0, rx_valid1}, 32'd0);
    chk("rst_data", {16'd0, rx_data0, rx_data1}, 32'd0);
    chk("rst_flags", {26'd0, fe0, pe0, ov0, fe1, pe1, ov1}, 32'd0);
    chk("rst_busy", {30'd0, busy0, busy1}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic 8N1 frame
    send_exp(0, 8'hA5, 1'b1, 1'b0);
    drain("a5");

    // Start-bit glitch is discarded, then a good frame
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy0}, 32'd1);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy0}, 32'd0);
    chk("glitch_no_word", {31'd0, rx_valid0}, 32'd0);
    send_exp(0, 8'h3C, 1'b1, 1'b0);
    drain("3c");

    // Stop bit low then line held low: one word only, no rearm while low
    e = '{data: 8'h5A, fe: 1'b1, pe: 1'b0, ov: 1'b0};
    q0.push_back(e);
    send(0, 8'h5A, 1'b0, 1'b0);
    repeat (3 * FRAME_CLKS) @(negedge clk);
    chk("low_line_idle", {31'd0, busy0}, 32'd0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    drain("5a");

    // Break from idle: one all-zero word with a framing error
    e = '{data: 8'h00, fe: 1'b1, pe: 1'b0, ov: 1'b0};
    q0.push_back(e);
    rx = 1'b0;
    repeat (3 * FRAME_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    drain("break");

    // Even parity receiver
    send_exp(1, 8'h07, 1'b1, 1'b1);
    send_exp(1, 8'h07, 1'b1, 1'b0);
    drain("par");

    // Overrun: consumer stalled across two frames
    mode0 = 2;
    repeat (4) @(negedge clk);
    e = '{data: 8'h11, fe: 1'b0, pe: 1'b0, ov: 1'b1};
    q0.push_back(e);
    send(0, 8'h11, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    send(0, 8'h22, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    chk("ovr_held_data", {24'd0, rx_data0}, 32'h11);
    chk("ovr_held_flag", {30'd0, rx_valid0, ov0}, 32'd3);
    mode0 = 0;
    drain("ovr");
    send_exp(0, 8'h33, 1'b1, 1'b0);
    drain("33");

    // Reset in the middle of the data bits of 0xFF
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("mid_busy", {31'd0, busy0}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_out", {21'd0, rx_valid0, rx_data0, fe0, pe0, ov0}, 32'd0);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("low_after_rst", {30'd0, busy0, rx_valid0}, 32'd0);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    send_exp(0, 8'h81, 1'b1, 1'b0);
    drain("81");

    // Randomised frames on both receivers with a jittery consumer
    mode0 = 1;
    mode1 = 1;
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      send_exp(0, d, st, 1'b0);
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = 1'($urandom_range(0, 1));
      send_exp(1, d, st, pb);
    end
    mode0 = 0;
    mode1 = 0;
    drain("rand");
    repeat (20) @(negedge clk);
    chk("final_idle", {28'd0, busy0, busy1, rx_valid0, rx_valid1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
